// File: rtl/dshot_pkg.sv
// dshot_pkg
// Shared definitions for the DShot receive path: frame length, the receiver
// FSM state type, and default timing constants for a 48 MHz system clock.
// Ports: none (package).
package dshot_pkg;

  localparam int DSHOT_FRAME_BITS = 16;

  // Clock cycles per bit at 48 MHz for the common DShot rates
  localparam int DSHOT150_BIT_PERIOD_48M = 320;
  localparam int DSHOT300_BIT_PERIOD_48M = 160;
  localparam int DSHOT600_BIT_PERIOD_48M = 80;

  // Glitch floor and inter-bit gap timeout used with DShot600 at 48 MHz
  localparam int DSHOT600_MIN_HIGH_48M   = 8;
  localparam int DSHOT600_GAP_48M        = 2 * DSHOT600_BIT_PERIOD_48M;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } dshot_state_t;

endpackage

// File: rtl/dshot_input_sync.sv
// dshot_input_sync
// Brings the asynchronous DShot line into the clk domain and produces
// registered one-cycle rise/fall pulses for the frame receiver.
// Optional macro DSHOT_GLITCH_FILTER_EN inserts a 3-sample majority filter
// after the synchronizer (adds 2 cycles of latency, rejects 1-cycle spikes).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   line - raw DShot input, asynchronous to clk
//   rise - one-cycle pulse on a qualified low->high transition
//   fall - one-cycle pulse on a high->low transition
module dshot_input_sync
  import dshot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise,
  output logic fall
);

  logic syncA;
  logic syncIn;
  logic level;
  logic prevLevel;
  logic armed;
  logic levelValid;

`ifdef DSHOT_GLITCH_FILTER_EN
  // Number of clocks after reset before the filtered level reflects the pin
  localparam int FILL_STAGES = 5;

  logic hist1;
  logic hist2;
  logic filtLevel;

  // Majority of the current and two previous synchronized samples; a pulse
  // of one cycle never gets two votes, wider pulses keep their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1     <= 1'b0;
      hist2     <= 1'b0;
      filtLevel <= 1'b0;
    end else begin
      hist1     <= syncIn;
      hist2     <= hist1;
      filtLevel <= (syncIn & hist1) | (syncIn & hist2) | (hist1 & hist2);
    end
  end

  assign level = filtLevel;
`else
  localparam int FILL_STAGES = 2;

  assign level = syncIn;
`endif

  logic [FILL_STAGES-1:0] fill;

  assign levelValid = fill[FILL_STAGES-1];

  // Synchronizer, edge detection and start-up qualification. The reset
  // value of the pipeline looks like a low line, so a line held high at
  // reset exit would fake a rising edge. fill marks when the pipeline holds
  // genuine pin samples, and rises are only passed on once a genuine low
  // has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA     <= 1'b0;
      syncIn    <= 1'b0;
      prevLevel <= 1'b0;
      fill      <= '0;
      armed     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      syncA     <= line;
      syncIn    <= syncA;
      prevLevel <= level;
      fill      <= {fill[FILL_STAGES-2:0], 1'b1};
      armed     <= armed | (levelValid & ~level);
      rise      <= armed & level & ~prevLevel;
      fall      <= ~level & prevLevel;
    end
  end

endmodule

// File: rtl/dshot_frame_receiver.sv
// dshot_frame_receiver
// Measures DShot pulse high times, decodes 16 bits MSB-first and publishes
// each complete frame on rawData with a one-cycle frameValid strobe.
// Glitches, over-long highs and inter-bit gaps abort the frame with a
// one-cycle frameError strobe; rawData is then left unchanged.
// Optional macro DSHOT_GLITCH_FILTER_EN (see dshot_input_sync): adds a
// majority filter, frame latency 6 clk instead of 4 clk.
// Parameters:
//   BIT_PERIOD_CYCLES - clk cycles per DShot bit, must be >= 16
//   MIN_HIGH_CYCLES   - shorter high pulses are treated as glitches
//   GAP_CYCLES        - low time that aborts an incomplete frame
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   dshotIn    - raw DShot line, asynchronous to clk
//   rawData    - last complete frame, MSB = first bit received
//   frameValid - one-cycle strobe, rawData updated this cycle
//   frameError - one-cycle strobe, frame aborted
//   busy       - high while a frame is in progress
module dshot_frame_receiver
  import dshot_pkg::*;
#(
  parameter int BIT_PERIOD_CYCLES = DSHOT600_BIT_PERIOD_48M,
  parameter int MIN_HIGH_CYCLES   = DSHOT600_MIN_HIGH_48M,
  parameter int GAP_CYCLES        = DSHOT600_GAP_48M
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dshotIn,
  output logic [15:0] rawData,
  output logic        frameValid,
  output logic        frameError,
  output logic        busy
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1) + 1;
  localparam int BIT_W = $clog2(DSHOT_FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_MAX     = CNT_W'(BIT_PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] HALF_PERIOD = CNT_W'(BIT_PERIOD_CYCLES / 2);
  localparam logic [CNT_W-1:0] MIN_HIGH    = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_MAX     = CNT_W'(GAP_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DSHOT_FRAME_BITS - 1);

  logic rise;
  logic fall;

  dshot_state_t                  state;
  logic [CNT_W-1:0]              highCnt;
  logic [CNT_W-1:0]              lowCnt;
  logic [BIT_W-1:0]              bitCnt;
  logic [DSHOT_FRAME_BITS-2:0]   shiftReg;
  logic                          bitValue;

  dshot_input_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .line (dshotIn),
    .rise (rise),
    .fall (fall)
  );

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

  // A pulse at least half a bit period long is a 1
  assign bitValue = (highCnt >= HALF_PERIOD);

  assign busy = (state != IDLE) || (bitCnt != '0);

  // Bit-timing FSM. highCnt equals the pin high time when the falling edge
  // arrives; lowCnt counts the low time since the last falling edge. Only
  // 15 bits are kept in shiftReg: the 16th bit goes straight into rawData.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      highCnt    <= '0;
      lowCnt     <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      rawData    <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            highCnt <= CNT_ONE;
          end
        end
        HIGH: begin
          if (highCnt > BIT_MAX) begin
            frameError <= 1'b1;
            bitCnt     <= '0;
            state      <= IDLE;
          end else if (fall) begin
            if (highCnt < MIN_HIGH) begin
              frameError <= 1'b1;
              bitCnt     <= '0;
              state      <= IDLE;
            end else if (bitCnt == LAST_BIT) begin
              rawData    <= {shiftReg, bitValue};
              frameValid <= 1'b1;
              bitCnt     <= '0;
              state      <= IDLE;
            end else begin
              shiftReg <= {shiftReg[DSHOT_FRAME_BITS-3:0], bitValue};
              bitCnt   <= bitCnt + 1'b1;
              lowCnt   <= CNT_ONE;
              state    <= LOW;
            end
          end else begin
            highCnt <= satInc(highCnt);
          end
        end
        LOW: begin
          // A rise in the same cycle as the timeout keeps the frame alive
          if (rise) begin
            state   <= HIGH;
            highCnt <= CNT_ONE;
          end else if (lowCnt >= GAP_MAX) begin
            frameError <= 1'b1;
            bitCnt     <= '0;
            state      <= IDLE;
          end else begin
            lowCnt <= satInc(lowCnt);
          end
        end
        default: begin
          bitCnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dshot_frame_receiver.sv
// tb_dshot_frame_receiver
// Self-checking bench for dshot_frame_receiver. Pulse trains are described
// as (high time, low time) pairs; a timeline model derives the expected
// strobes, their cycle and rawData from the pulse timing rules, and the
// strobes seen on the DUT are compared against it.
// Honours DSHOT_GLITCH_FILTER_EN (latency 6, spike rejection test).
module tb_dshot_frame_receiver;

  localparam int BIT_PERIOD = 80;
  localparam int MIN_HIGH   = 8;
  localparam int GAP        = 160;
`ifdef DSHOT_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic        clk;
  logic        rst;
  logic        dshotIn;
  logic [15:0] rawData;
  logic        frameValid;
  logic        frameError;
  logic        busy;

  typedef struct packed {
    int          highT;
    int          lowT;
    logic        spike;
  } pulse_t;

  typedef struct packed {
    int          cyc;
    logic        isValid;
    logic [15:0] data;
  } evt_t;

  pulse_t      pulseQ[$];
  evt_t        seenQ[$];
  evt_t        expQ[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        bothHigh = 1'b0;
  logic [15:0] modelRaw = 16'h0000;

  dshot_frame_receiver #(
    .BIT_PERIOD_CYCLES (BIT_PERIOD),
    .MIN_HIGH_CYCLES   (MIN_HIGH),
    .GAP_CYCLES        (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dshotIn    (dshotIn),
    .rawData    (rawData),
    .frameValid (frameValid),
    .frameError (frameError),
    .busy       (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index used as the common time base
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe shortly after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (frameValid || frameError) seenQ.push_back('{cyc, frameValid, rawData});
    if (frameValid && frameError) bothHigh = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline model: pin-time rules for decode, glitch, over-long high and
  // gap timeout, shifted by the pipeline latency.
  task automatic runModel(input int startCyc);
    int t;
    int bits;
    logic [15:0] data;
    t    = startCyc;
    bits = 0;
    data = 16'h0000;
    foreach (pulseQ[i]) begin
      int h;
      int l;
      int fallT;
      h     = pulseQ[i].highT;
      l     = pulseQ[i].lowT;
      fallT = t + h;
      if (h > BIT_PERIOD) begin
        expQ.push_back('{t + BIT_PERIOD + 1 + LAT, 1'b0, modelRaw});
        bits = 0;
      end else if (h < MIN_HIGH) begin
        expQ.push_back('{fallT + LAT, 1'b0, modelRaw});
        bits = 0;
      end else begin
        data = {data[14:0], (h >= BIT_PERIOD / 2)};
        bits++;
        if (bits == 16) begin
          modelRaw = data;
          expQ.push_back('{fallT + LAT, 1'b1, modelRaw});
          bits = 0;
        end else if (l > GAP) begin
          expQ.push_back('{fallT + LAT + GAP, 1'b0, modelRaw});
          bits = 0;
        end
      end
      t = fallT + l;
    end
  endtask

  // Drive the queued pulse train, starting on a falling clock edge
  task automatic applyStimulus();
    int t;
    @(negedge clk);
    t = cyc;
    runModel(t);
    foreach (pulseQ[i]) begin
      dshotIn = 1'b1;
      repeat (pulseQ[i].highT) @(negedge clk);
      dshotIn = 1'b0;
      if (pulseQ[i].spike) begin
        repeat (pulseQ[i].lowT / 2) @(negedge clk);
        dshotIn = 1'b1;
        @(negedge clk);
        dshotIn = 1'b0;
        repeat (pulseQ[i].lowT - pulseQ[i].lowT / 2 - 1) @(negedge clk);
      end else begin
        repeat (pulseQ[i].lowT) @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic addPulse(input int h, input int l, input logic spike);
    pulseQ.push_back('{h, l, spike});
  endtask

  task automatic addBits(input logic [15:0] val, input int nBits, input logic randomTiming,
                         input int lastLow, input logic spike);
    for (int i = 15; i > 16 - nBits - 1; i--) begin
      int h;
      int l;
      if (randomTiming) begin
        h = val[i] ? int'($urandom_range(40, 80)) : int'($urandom_range(8, 39));
        l = int'($urandom_range(3, 160));
      end else begin
        h = val[i] ? 60 : 30;
        l = val[i] ? 20 : 50;
      end
      if (i == 16 - nBits) l = lastLow;
      addPulse(h, l, spike);
    end
  endtask

  task automatic compareEvents(input string tag);
    checkOutput({tag, " strobe count"}, seenQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
      checkOutput($sformatf("%s ev%0d cycle", tag, i), seenQ[i].cyc, expQ[i].cyc);
      checkOutput($sformatf("%s ev%0d kind", tag, i), {31'd0, seenQ[i].isValid}, {31'd0, expQ[i].isValid});
      checkOutput($sformatf("%s ev%0d rawData", tag, i), {16'd0, seenQ[i].data}, {16'd0, expQ[i].data});
    end
    seenQ.delete();
    expQ.delete();
    pulseQ.delete();
  endtask

  initial begin
    // Reset with the line held high
    rst     = 1'b1;
    dshotIn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rawData", {16'd0, rawData}, 32'd0);
    checkOutput("reset frameValid", {31'd0, frameValid}, 32'd0);
    checkOutput("reset frameError", {31'd0, frameError}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    checkOutput("held-high ignored strobes", seenQ.size(), 0);
    checkOutput("held-high ignored busy", {31'd0, busy}, 32'd0);
    dshotIn = 1'b0;
    repeat (20) @(negedge clk);
    seenQ.delete();

    $display("[TB] nominal frame 82C6");
    addBits(16'h82C6, 16, 1'b0, 200, 1'b0);
    applyStimulus();
    checkOutput("nominal rawData", {16'd0, rawData}, 32'h82C6);
    compareEvents("nominal");

    $display("[TB] threshold frame A5C3");
    begin
      logic [15:0] pat;
      int ones;
      int zeros;
      pat   = 16'hA5C3;
      ones  = 0;
      zeros = 0;
      for (int i = 15; i >= 0; i--) begin
        int h;
        if (pat[i]) begin
          h = (ones % 2 == 0) ? 40 : 80;
          ones++;
        end else begin
          h = (zeros % 2 == 0) ? 39 : 8;
          zeros++;
        end
        addPulse(h, (i == 13) ? 160 : ((i == 0) ? 200 : 20), 1'b0);
      end
    end
    applyStimulus();
    checkOutput("threshold rawData", {16'd0, rawData}, 32'hA5C3);
    compareEvents("threshold");

    $display("[TB] truncated frame");
    addBits(16'h1234, 10, 1'b0, 200, 1'b0);
    applyStimulus();
    checkOutput("truncated rawData kept", {16'd0, rawData}, 32'hA5C3);
    checkOutput("truncated busy", {31'd0, busy}, 32'd0);
    compareEvents("truncated");

    $display("[TB] short glitch then FFFF");
    addBits(16'hA000, 5, 1'b0, 20, 1'b0);
    addPulse(4, 50, 1'b0);
    addBits(16'hFFFF, 16, 1'b0, 200, 1'b0);
    applyStimulus();
    checkOutput("glitch recovery rawData", {16'd0, rawData}, 32'hFFFF);
    compareEvents("glitch");

    $display("[TB] over-long high");
    addPulse(100, 200, 1'b0);
    applyStimulus();
    compareEvents("longhigh");

    $display("[TB] reset mid-frame");
    addBits(16'hC3C3, 8, 1'b0, 20, 1'b0);
    applyStimulus();
    checkOutput("midframe busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset rawData", {16'd0, rawData}, 32'd0);
    checkOutput("midreset frameValid", {31'd0, frameValid}, 32'd0);
    checkOutput("midreset frameError", {31'd0, frameError}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    modelRaw = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    compareEvents("midreset quiet");
    addBits(16'h0001, 16, 1'b0, 200, 1'b0);
    applyStimulus();
    checkOutput("post-reset rawData", {16'd0, rawData}, 32'h0001);
    compareEvents("postreset");

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      addBits(16'($urandom), 16, 1'b1, 200, 1'b0);
    end
    applyStimulus();
    compareEvents("randframes");

    $display("[TB] random mixed pulse train");
    for (int p = 0; p < 50; p++) begin
      int r;
      int h;
      int l;
      r = int'($urandom_range(0, 11));
      h = int'($urandom_range(8, 80));
      l = int'($urandom_range(3, 160));
      if (r == 0) h = int'($urandom_range(4, 7));
      if (r == 1) h = int'($urandom_range(81, 100));
      if (r == 2) l = int'($urandom_range(161, 190));
      addPulse(h, (p == 49) ? 200 : l, 1'b0);
    end
    applyStimulus();
    compareEvents("randmixed");

`ifdef DSHOT_GLITCH_FILTER_EN
    $display("[TB] spikes on low line");
    addBits(16'h3A5C, 16, 1'b0, 200, 1'b1);
    applyStimulus();
    checkOutput("spike rawData", {16'd0, rawData}, 32'h3A5C);
    compareEvents("spike");
`endif

    checkOutput("strobes exclusive", {31'd0, bothHigh}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
